// File: rtl/pc_redirect_unit.sv
// Fetch PC unit: selects trap vector > taken branch > PC+4 and defers redirects across stalls.
// Optional branch statistics counters are enabled with `define BRANCH_STATS_EN.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        ex_valid_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        trap_i,
  input  logic [31:0] trap_vec_i,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o,
`ifdef BRANCH_STATS_EN
  output logic [CNT_W-1:0] taken_cnt_o,
  output logic [CNT_W-1:0] not_taken_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o,
`endif
  output logic        pend_o
);

  localparam int unsigned XLEN = 32;
  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_PEND = 1'b1;

  logic [0:0]      state, state_n;
  logic [XLEN-1:0] pend_tgt, pend_tgt_n;
  logic [XLEN-1:0] pc_n, mis_addr_n, target;
  logic            mis_n, flush, br_taken_any, br_req, bad_br, req;

  assign br_taken_any = ex_valid_i & br_taken_i;
  assign br_req       = br_taken_any & (br_target_i[1:0] == 2'b00);
  assign bad_br       = br_taken_any & (br_target_i[1:0] != 2'b00);
  assign req          = trap_i | br_req;
  assign target       = trap_i ? trap_vec_i : br_target_i;

  // Flush and pend are forced low while reset is being sampled.
  assign flush_o = flush & rst_n;
  assign pend_o  = (state == S_PEND) & rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_RUN;
      pc_o            <= RESET_PC;
      pend_tgt        <= '0;
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      state           <= state_n;
      pc_o            <= pc_n;
      pend_tgt        <= pend_tgt_n;
      misalign_o      <= mis_n;
      misalign_addr_o <= mis_addr_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc_o;
    pend_tgt_n = pend_tgt;
    flush      = 1'b0;
    mis_n      = 1'b0;
    mis_addr_n = misalign_addr_o;
    case (state)
      S_RUN: begin
        if (req && !stall_i) begin
          pc_n  = target;
          flush = 1'b1;
        end else if (req) begin
          pend_tgt_n = target;
          state_n    = S_PEND;
        end else if (!stall_i) begin
          pc_n = pc_o + XLEN'(4);
        end
        // A stalled bad branch is re-presented, so report it only when it moves on.
        if (bad_br && !stall_i) begin
          mis_n      = 1'b1;
          mis_addr_n = br_target_i;
        end
      end
      S_PEND: begin
        if (trap_i) pend_tgt_n = trap_vec_i;
        if (!stall_i) begin
          pc_n    = trap_i ? trap_vec_i : pend_tgt;
          flush   = 1'b1;
          state_n = S_RUN;
        end
      end
      default: state_n = S_RUN;
    endcase
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      taken_cnt_o     <= '0;
      not_taken_cnt_o <= '0;
      redirect_cnt_o  <= '0;
    end else begin
      if (state == S_RUN && br_taken_any && !stall_i) taken_cnt_o <= taken_cnt_o + CNT_W'(1);
      if (ex_valid_i && !br_taken_i && !stall_i) not_taken_cnt_o <= not_taken_cnt_o + CNT_W'(1);
      if (flush) redirect_cnt_o <= redirect_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed and randomized bench for pc_redirect_unit against a behavioural next-PC model.
// Build with `define BRANCH_STATS_EN to also check the statistics counters.
module tb_pc_redirect_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, stall_i, ex_valid_i, br_taken_i, trap_i;
  logic [31:0] br_target_i, trap_vec_i;
  logic [31:0] pc_o, misalign_addr_o;
  logic        flush_o, misalign_o, pend_o;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt_o, not_taken_cnt_o, redirect_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: architectural view of the unit
  logic        m_valid = 1'b0;
  logic [31:0] m_pc, m_pend_tgt, m_mis_addr;
  logic        m_pend, m_mis;
  logic [31:0] m_taken, m_ntaken, m_redir;

  pc_redirect_unit #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ex_valid_i(ex_valid_i),
    .br_taken_i(br_taken_i), .br_target_i(br_target_i), .trap_i(trap_i),
    .trap_vec_i(trap_vec_i), .pc_o(pc_o), .flush_o(flush_o),
    .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o),
`ifdef BRANCH_STATS_EN
    .taken_cnt_o(taken_cnt_o), .not_taken_cnt_o(not_taken_cnt_o),
    .redirect_cnt_o(redirect_cnt_o),
`endif
    .pend_o(pend_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs mid-low-phase, check outputs, then advance the model.
  task automatic step(input logic r, input logic s, input logic v, input logic t,
                      input logic [31:0] tg, input logic tr, input logic [31:0] tv);
    logic        taken, aligned, want_redirect, exp_flush;
    logic [31:0] dest;
    @(negedge clk);
    rst_n = r; stall_i = s; ex_valid_i = v; br_taken_i = t;
    br_target_i = tg; trap_i = tr; trap_vec_i = tv;
    #1;
    taken   = v && t;
    aligned = (tg % 4) == 0;
    // A pending redirect always fires on release; otherwise a trap or aligned taken branch does.
    want_redirect = m_pend ? 1'b1 : (tr || (taken && aligned));
    exp_flush = r && !s && want_redirect;
    check("flush", 32'(flush_o), 32'(exp_flush));
    check("pend", 32'(pend_o), 32'(m_pend && r));
    if (m_valid) begin
      check("pc", pc_o, m_pc);
      check("misalign", 32'(misalign_o), 32'(m_mis));
      check("misalign_addr", misalign_addr_o, m_mis_addr);
`ifdef BRANCH_STATS_EN
      check("taken_cnt", taken_cnt_o, m_taken);
      check("not_taken_cnt", not_taken_cnt_o, m_ntaken);
      check("redirect_cnt", redirect_cnt_o, m_redir);
`endif
    end
    if (!r) begin
      m_valid = 1'b1; m_pc = RST_PC; m_pend = 1'b0; m_pend_tgt = 0;
      m_mis = 1'b0; m_mis_addr = 0; m_taken = 0; m_ntaken = 0; m_redir = 0;
    end else begin
      if (!m_pend && taken && !s) m_taken++;
      if (v && !t && !s) m_ntaken++;
      if (exp_flush) m_redir++;
      m_mis = !m_pend && !s && taken && !aligned;
      if (m_mis) m_mis_addr = tg;
      dest = tr ? tv : (m_pend ? m_pend_tgt : tg);
      if (m_pend) begin
        if (tr) m_pend_tgt = tv;
        if (!s) begin m_pc = dest; m_pend = 1'b0; end
      end else if (want_redirect) begin
        if (s) begin m_pend = 1'b1; m_pend_tgt = dest; end
        else m_pc = dest;
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic idle(input logic s);
    step(1'b1, s, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic [31:0] tg, tv;
    logic        r, s, v, t, tr;
    m_pc = 0; m_pend = 0; m_pend_tgt = 0; m_mis = 0; m_mis_addr = 0;
    m_taken = 0; m_ntaken = 0; m_redir = 0;

    // Reset then free run to 0x10
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    repeat (4) idle(1'b0);
    // Taken branch at 0x10
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    idle(1'b0); idle(1'b0);
    // Stalled branch to 0x200, held through the stall and the release cycle
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
    idle(1'b0); idle(1'b0);
    // Trap wins over a simultaneous branch
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 32'h80);
    idle(1'b0);
    // Pending 0x300 replaced by a trap to 0x80
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1, 32'h80);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1'b0);
    // Misaligned target, also presented during a stall first
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h102, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 1'b0, 32'h0);
    idle(1'b0); idle(1'b0);
    // Wrap at top of address space
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    idle(1'b0); idle(1'b0);
    // Reset while pending discards the pending target
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
    idle(1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(1'b0); idle(1'b0); idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(99) >= 2);
      s  = ($urandom_range(99) < 30);
      v  = ($urandom_range(99) < 60);
      t  = ($urandom_range(99) < 50);
      tr = ($urandom_range(99) < 8);
      tg = $urandom;
      if ($urandom_range(99) < 85) tg = tg & 32'hFFFF_FFFC;
      if ($urandom_range(99) < 8) tg = 32'hFFFF_FFF0 | (tg & 32'hF);
      tv = $urandom & 32'hFFFF_FFFC;
      step(r, s, v, t, tg, tr, tv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
